// File: rtl/muldiv_pkg.sv
// Shared encodings for the EXE-stage M-extension sequencer:
// FSM state codes and RV32M funct3 values.
package muldiv_pkg;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_MUL_WAIT = 2'd1;
    localparam logic [1:0] ENC_DIV_RUN  = 2'd2;
    localparam logic [1:0] ENC_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_MUL_WAIT = ENC_MUL_WAIT,
        ST_DIV_RUN  = ENC_DIV_RUN,
        ST_DONE     = ENC_DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_div_cache.sv
// One-entry operand tag for the divider: lets a REM reuse the
// remainder of a preceding DIV on identical operands.
module muldiv_div_cache
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            capture,
    input  logic            invalidate,
    input  logic            set_valid,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            uns,
    output logic            hit
);

    logic [XLEN-1:0] tag_a;
    logic [XLEN-1:0] tag_b;
    logic            tag_uns;
    logic            cache_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cache_valid <= 1'b0;
            tag_a       <= '0;
            tag_b       <= '0;
            tag_uns     <= 1'b0;
        end else begin
            if (invalidate) begin
                cache_valid <= 1'b0;
            end else if (set_valid) begin
                cache_valid <= 1'b1;
            end
            if (capture) begin
                tag_a   <= opA;
                tag_b   <= opB;
                tag_uns <= uns;
            end
        end
    end

    assign hit = cache_valid && (opA == tag_a) && (opB == tag_b)
              && (uns == tag_uns);

endmodule

// File: rtl/muldiv_sequencer.sv
// Start/stall sequencer for the fixed-latency multiplier and the
// iterative divider, with flush abort and DIV->REM result reuse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            exe_valid,
    input  logic            exe_is_muldiv,
    input  logic [2:0]      exe_funct3,
    input  logic [XLEN-1:0] exe_opA,
    input  logic [XLEN-1:0] exe_opB,
    input  logic            exe_hold_ext,
    input  logic            flush,
    input  logic            div_done,
    output logic            mul_start,
    output logic            div_start,
    output logic            div_signed,
    output logic            div_abort,
    output logic            mul_stall,
    output logic            div_running,
    output logic            result_valid,
    output logic            use_cache
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             go;
    logic             is_mul;
    logic             hit;
    logic             issue_mul;
    logic             issue_div;
    logic             take_hit;
    logic             in_div;

    assign in_div    = (state == ST_DIV_RUN);
    assign go        = exe_valid & exe_is_muldiv & ~exe_hold_ext
                     & ~flush & (state == ST_IDLE);
    assign is_mul    = (exe_funct3 < F3_DIV);
    assign issue_mul = go & is_mul;
    assign take_hit  = go & ~is_mul & hit;
    assign issue_div = go & ~is_mul & ~hit;

    muldiv_div_cache #(.XLEN(XLEN)) u_cache (
        .clk        (clk),
        .nrst       (nrst),
        .capture    (issue_div),
        .invalidate (issue_div | (flush & in_div)),
        .set_valid  (in_div & div_done & ~flush),
        .opA        (exe_opA),
        .opB        (exe_opB),
        .uns        (exe_funct3[0]),
        .hit        (hit)
    );

    // nrst gating keeps outputs low while reset is held, even if EXE
    // presents a startable op during the async reset window.
    always_comb begin
        mul_start    = nrst & issue_mul;
        div_start    = nrst & issue_div;
        div_signed   = nrst & ~flush & ~exe_funct3[0];
        div_abort    = nrst & flush & in_div;
        mul_stall    = nrst & ~flush
                     & (issue_mul | (state == ST_MUL_WAIT));
        div_running  = nrst & ~flush & (issue_div | in_div);
        result_valid = nrst & ~flush
                     & (take_hit | (state == ST_DONE));
        use_cache    = nrst & take_hit;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (issue_mul) begin
                        if (MUL_CYCLES == 1) begin
                            state <= ST_DONE;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= ST_MUL_WAIT;
                        end
                    end else if (issue_div) begin
                        state <= ST_DIV_RUN;
                    end
                end
                ST_MUL_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_DONE;
                    end
                end
                ST_DIV_RUN: begin
                    if (div_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!exe_hold_ext) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: instruction-level model plus
// a behavioural divider with programmable completion latency.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int MULC = 2;

    logic            clk = 1'b0;
    logic            nrst;
    logic            exe_valid;
    logic            exe_is_muldiv;
    logic [2:0]      exe_funct3;
    logic [XLEN-1:0] exe_opA;
    logic [XLEN-1:0] exe_opB;
    logic            exe_hold_ext;
    logic            flush;
    logic            div_done;
    logic            mul_start;
    logic            div_start;
    logic            div_signed;
    logic            div_abort;
    logic            mul_stall;
    logic            div_running;
    logic            result_valid;
    logic            use_cache;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN(XLEN), .MUL_CYCLES(MULC), .CNT_W(4)
    ) dut (
        .clk(clk), .nrst(nrst),
        .exe_valid(exe_valid), .exe_is_muldiv(exe_is_muldiv),
        .exe_funct3(exe_funct3), .exe_opA(exe_opA), .exe_opB(exe_opB),
        .exe_hold_ext(exe_hold_ext), .flush(flush), .div_done(div_done),
        .mul_start(mul_start), .div_start(div_start),
        .div_signed(div_signed), .div_abort(div_abort),
        .mul_stall(mul_stall), .div_running(div_running),
        .result_valid(result_valid), .use_cache(use_cache)
    );

    typedef struct {
        bit is_flush;
        bit abort;
        int uc;
        int ms;
        int dr;
        int nms;
        int nds;
        bit sgn;
        int rv;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // behavioural divider: done pulse div_lat cycles after start
    int div_lat;
    int dcnt;
    bit dbusy;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dbusy    <= 1'b0;
            dcnt     <= 0;
            div_done <= 1'b0;
        end else begin
            div_done <= 1'b0;
            if (div_abort) begin
                dbusy <= 1'b0;
            end else if (div_start) begin
                if (div_lat == 1) begin
                    div_done <= 1'b1;
                end else begin
                    dbusy <= 1'b1;
                    dcnt  <= div_lat - 1;
                end
            end else if (dbusy) begin
                if (dcnt == 1) begin
                    div_done <= 1'b1;
                    dbusy    <= 1'b0;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
        end
    end

    // monitor: accumulate per-instruction activity, compare at retire/flush
    int a_ms, a_dr, a_nms, a_nds, a_rv, a_uc;
    bit a_sgn;
    exp_t e;

    task automatic clr_acc();
        a_ms = 0; a_dr = 0; a_nms = 0; a_nds = 0;
        a_rv = 0; a_uc = 0; a_sgn = 0;
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            clr_acc();
        end else begin
            a_ms  += int'(mul_stall);
            a_dr  += int'(div_running);
            a_nms += int'(mul_start);
            a_nds += int'(div_start);
            a_rv  += int'(result_valid);
            a_uc  += int'(use_cache);
            if (div_start) a_sgn = div_signed;
            if (div_abort && !flush) check("abort_no_flush", 1, 0);
            if (flush) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL flush_unexpected: got flush expected none");
                end else begin
                    e = sbq.pop_front();
                    check("flush_kind", 1, int'(e.is_flush));
                    check("div_abort", int'(div_abort), int'(e.abort));
                    check("flush_quiet", int'({mul_start, div_start,
                          div_signed, mul_stall, div_running,
                          result_valid, use_cache}), 0);
                end
                clr_acc();
            end else if (result_valid && !exe_hold_ext) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL retire_unexpected: got result expected none");
                end else begin
                    e = sbq.pop_front();
                    check("retire_kind", 0, int'(e.is_flush));
                    check("use_cache", a_uc, e.uc);
                    check("mul_stall_cycles", a_ms, e.ms);
                    check("div_running_cycles", a_dr, e.dr);
                    check("mul_start_count", a_nms, e.nms);
                    check("div_start_count", a_nds, e.nds);
                    check("result_valid_cycles", a_rv, e.rv);
                    if (e.nds == 1) check("div_signed", int'(a_sgn), int'(e.sgn));
                end
                clr_acc();
            end
        end
    end

    // reference model of the operand cache
    bit        m_valid = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    bit        m_uns = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flush(input bit ab);
        exp_t x;
        x = '{1'b1, ab, 0, 0, 0, 0, 0, 1'b0, 0};
        sbq.push_back(x);
    endtask

    task automatic push_ret(input int uc, ms, dr, nms, nds,
                            input bit sgn, input int rv);
        exp_t x;
        x = '{1'b0, 1'b0, uc, ms, dr, nms, nds, sgn, rv};
        sbq.push_back(x);
    endtask

    task automatic do_flush(input bit ab);
        push_flush(ab);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exe_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int lat, pre, post,
                         flush_at);
        bit mul, hit;
        int s, fa;
        mul = (f3[2] == 1'b0);
        hit = !mul && m_valid && a == m_a && b == m_b && f3[0] == m_uns;
        s   = mul ? MULC : (hit ? 0 : lat + 1);
        fa  = (flush_at > s) ? s : flush_at;
        exe_valid = 1; exe_is_muldiv = 1; exe_funct3 = f3;
        exe_opA = a; exe_opB = b; flush = 0; div_lat = lat;
        exe_hold_ext = 1;
        repeat (pre) step();
        exe_hold_ext = 0;
        if (fa == 0) begin
            do_flush(1'b0);
            return;
        end
        if (hit) begin
            push_ret(1, 0, 0, 0, 0, 1'b0, 1);
            step();
            exe_valid = 0;
            return;
        end
        if (!mul) begin
            m_valid = 0; m_a = a; m_b = b; m_uns = f3[0];
        end
        for (int k = 0; k < s; k++) begin
            if (k == fa) begin
                do_flush(!mul);
                if (!mul) m_valid = 0;
                return;
            end
            step();
        end
        if (!mul) m_valid = 1;
        if (fa == s) begin
            do_flush(1'b0);
            return;
        end
        exe_hold_ext = 1;
        repeat (post) step();
        exe_hold_ext = 0;
        push_ret(0, mul ? s : 0, mul ? 0 : s, mul ? 1 : 0, mul ? 0 : 1,
                 ~f3[0], post + 1);
        step();
        exe_valid = 0;
    endtask

    task automatic reset_mid_div(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input int cyc);
        exe_valid = 1; exe_is_muldiv = 1; exe_funct3 = f3;
        exe_opA = a; exe_opB = b; exe_hold_ext = 0; flush = 0;
        div_lat = 40;
        m_valid = 0;
        repeat (cyc) step();
        #2;
        nrst = 0;
        #1;
        check("async_rst_outs", int'({mul_start, div_start, div_signed,
              div_abort, mul_stall, div_running, result_valid,
              use_cache}), 0);
        step();
        exe_valid = 0;
        nrst = 1;
        step();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, la, lb;
        int          fsel;
        nrst = 0; exe_valid = 1; exe_is_muldiv = 1; exe_funct3 = F3_MUL;
        exe_opA = 7; exe_opB = 6; exe_hold_ext = 0; flush = 0; div_lat = 1;
        #3;
        check("reset_outs", int'({mul_start, div_start, div_signed,
              div_abort, mul_stall, div_running, result_valid,
              use_cache}), 0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1; exe_valid = 0;
        step();

        do_op(F3_MUL, 7, 6, 1, 0, 0, -1);
        do_op(F3_DIV, 100, 7, 33, 0, 0, -1);
        do_op(F3_REM, 100, 7, 1, 0, 0, -1);
        do_op(F3_DIVU, 100, 7, 5, 0, 0, -1);
        do_op(F3_REM, 100, 7, 5, 0, 0, -1);
        do_op(F3_DIV, 100, 7, 10, 0, 0, 10);
        do_op(F3_REM, 100, 7, 6, 0, 0, -1);
        do_op(F3_MUL, 3, 4, 1, 0, 3, -1);
        do_op(F3_DIVU, 9, 2, 4, 0, 3, -1);
        do_op(F3_REMU, 9, 2, 4, 1, 2, -1);
        do_op(F3_DIV, 100, 7, 8, 0, 0, -1);
        reset_mid_div(F3_DIVU, 100, 7, 6);
        do_op(F3_REMU, 100, 7, 3, 0, 0, -1);

        la = 100; lb = 7;
        for (int i = 0; i < 90; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                a = la; b = lb;
                f3[2] = 1'b1;
                if ($urandom_range(0, 5) == 0) b = lb ^ 32'h1;
            end else begin
                a = $urandom; b = $urandom;
            end
            fsel = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 41)) : -1;
            do_op(f3, a, b, int'($urandom_range(1, 40)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), fsel);
            la = a; lb = b;
            repeat ($urandom_range(0, 2)) begin
                exe_valid = 1'($urandom);
                exe_is_muldiv = 0;
                exe_funct3 = 3'($urandom_range(0, 7));
                step();
            end
            exe_valid = 0;
        end

        repeat (3) step();
        check("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the EXE-stage M-extension units: a fixed-latency multiplier and an iterative divider with a start/done handshake.
- Issues unit starts and produces the `mul_stall` and `div_running` stall sources consumed by the pipeline stall/flush controller.
- Aborts in-flight work on a pipeline flush.
- Keeps a one-entry operand cache so that DIV followed by REM (or DIVU followed by REMU) on identical operands completes with no stall, using the quotient/remainder the divider still holds.

Parameters:
- XLEN, 32, operand width.
- MUL_CYCLES, 2, multiplier latency in cycles. Legal range 1..15.
- CNT_W, 4, width of the latency counter. Must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- exe_valid  in  1  EXE stage holds a valid (non-bubble) instruction.
- exe_is_muldiv  in  1  EXE instruction is OP with funct7=0000001.
- exe_funct3  in  3  M-op select: 0xx = MUL*, 1x0 = signed div/rem, 1x1 = unsigned.
- exe_opA  in  XLEN  forwarded rs1 value.
- exe_opB  in  XLEN  forwarded rs2 value.
- exe_hold_ext  in  1  EXE held by stall sources other than this block. Must not include mul_stall/div_running (no combinational loop).
- flush  in  1  EXE instruction is being squashed (branch/jump/ISR flush).
- div_done  in  1  divider completion pulse. Divider holds Q/R until its next div_start.
- mul_start  out  1  one-cycle start pulse to multiplier.
- div_start  out  1  one-cycle start pulse to divider.
- div_signed  out  1  equals ~exe_funct3[0]; valid when div_start=1.
- div_abort  out  1  one-cycle cancel to divider.
- mul_stall  out  1  stall request (multiply in progress).
- div_running  out  1  stall request (divide in progress).
- result_valid  out  1  unit result may be selected by EXE this cycle.
- use_cache  out  1  result comes from held divider outputs (cache hit).

Behaviour:
- States: IDLE, MUL_WAIT, DIV_RUN, DONE. Reset (async, nrst=0) forces:
  - state=IDLE, cnt=0, cache_valid=0;
  - all outputs 0. Reset mid-operation abandons all work with no abort pulse.
- Derived terms:
  - go = exe_valid & exe_is_muldiv & ~exe_hold_ext & ~flush (IDLE only).
  - is_mul = ~exe_funct3[2].
  - hit = cache_valid & opA==tagA & opB==tagB & exe_funct3[0]==tag_uns.
- IDLE, go & is_mul:
  - mul_start=1, mul_stall=1.
  - If MUL_CYCLES==1, go to DONE; otherwise cnt<=MUL_CYCLES-1 and go to MUL_WAIT.
- IDLE, go & ~is_mul & hit:
  - use_cache=1, result_valid=1; no stall, no start; stay in IDLE.
- IDLE, go & ~is_mul & ~hit:
  - div_start=1, div_running=1, cache_valid<=0.
  - Latch tagA/tagB/tag_uns from the current operands; go to DIV_RUN.
- MUL_WAIT:
  - mul_stall=1, cnt decrements.
  - In the cycle cnt==1, the next state is DONE.
  - Total mul_stall cycles = MUL_CYCLES.
- DIV_RUN:
  - div_running=1.
  - On div_done: cache_valid<=1, go to DONE.
  - Stall stays asserted in the div_done cycle.
- DONE:
  - No stall, result_valid=1.
  - The start condition is suppressed, so the same instruction is never re-issued.
  - Stay while exe_hold_ext=1; go to IDLE when exe_hold_ext=0 (EXE advances at this edge).
- flush has priority over every transition, including a simultaneous div_done:
  - any state goes to IDLE next cycle;
  - all outputs are 0 that cycle except div_abort;
  - in DIV_RUN, div_abort=1 for that single cycle and cache_valid<=0;
  - in IDLE, flush suppresses start and hit.
- Outputs are combinational from state and inputs. State, cnt and tags are registered.
- Operand compare is full XLEN equality. Operands are not stored beyond the tags.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding localparams (2-bit);
  - funct3 constants (F3_MUL..F3_REMU).
- One natural sub-module: muldiv_div_cache.
  - Contents: tag registers, cache_valid, equality compare.
  - Ports: clk, nrst, capture, invalidate, set_valid, opA, opB, uns, hit.

Test Plan:
- MUL (funct3=000, opA=7, opB=6), MUL_CYCLES=2 -> mul_start for 1 cycle, mul_stall for exactly 2 cycles, result_valid in cycle 3, next EXE instruction not restarted.
- DIV 100/7 with div_done 33 cycles after start, followed by REM 100/7 -> first op: div_running for 34 cycles, then DONE. Second op: use_cache=1, result_valid=1, zero stall, no div_start.
- DIVU 100/7 followed by REM 100/7 (signedness mismatch) -> cache miss, new div_start, div_signed=1.
- DIV in progress, flush asserted in cycle 10 together with div_done -> div_abort pulse, IDLE next cycle, cache_valid=0. A following REM with the same operands misses and restarts.
- DONE with exe_hold_ext=1 for 3 cycles -> result_valid held for 4 cycles, no second mul_start/div_start.
- nrst pulled low mid-DIV_RUN -> all outputs 0 immediately (asynchronous), state IDLE, cache invalid after release.
